// File: rtl/rt_block_writer_pkg.sv
// Shared constants for the real-time block writer: bus address offset,
// DAC quadlet flag positions and the replay state encoding.
package rt_block_writer_pkg;

    localparam logic [3:0] OFF_DAC_CTRL     = 4'h0;
    localparam int         RT_DAC_VALID_BIT = 31;
    localparam int         RT_AMP_EN_BIT    = 29;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WSTART    = 3'd1;
    localparam logic [2:0] ST_WRITE     = 3'd2;
    localparam logic [2:0] ST_WRITE_GAP = 3'd3;
    localparam logic [2:0] ST_BLK_WEN   = 3'd4;
    localparam logic [2:0] ST_WQUAD_GAP = 3'd5;
    localparam logic [2:0] ST_WQUAD     = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_WSTART    = ST_WSTART,
        S_WRITE     = ST_WRITE,
        S_WRITE_GAP = ST_WRITE_GAP,
        S_BLK_WEN   = ST_BLK_WEN,
        S_WQUAD_GAP = ST_WQUAD_GAP,
        S_WQUAD     = ST_WQUAD
    } state_t;

endpackage

// File: rtl/rt_block_writer_chan_select.sv
// Channel sequencing for the block writer: flag reductions and first/next channel.
// With RT_SKIP_IDLE_CHAN_EN defined, channels without valid/amp-enable are skipped.
module rt_chan_select
    import rt_block_writer_pkg::*;
#(
    parameter int NUM_MOTORS = 4
) (
    input  logic [NUM_MOTORS-1:0] i_valid,
    input  logic [NUM_MOTORS-1:0] i_amp_en,
    input  logic [3:0]            i_cur,
    output logic                  o_any_valid,
    output logic                  o_any_active,
    output logic [3:0]            o_first,
    output logic                  o_first_ok,
    output logic [3:0]            o_next,
    output logic                  o_next_ok
);

    logic [NUM_MOTORS-1:0] w_active;
    logic [NUM_MOTORS-1:0] w_elig;

    assign w_active     = i_valid | i_amp_en;
    assign o_any_valid  = |i_valid;
    assign o_any_active = |w_active;

`ifdef RT_SKIP_IDLE_CHAN_EN
    assign w_elig = w_active;
`else
    assign w_elig = '1;
`endif

    // Descending scan so the lowest eligible index wins.
    always_comb begin
        o_first    = '0;
        o_first_ok = 1'b0;
        o_next     = '0;
        o_next_ok  = 1'b0;
        for (int i = NUM_MOTORS - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                o_first    = 4'(i);
                o_first_ok = 1'b1;
            end
            if (w_elig[i] && (4'(i) > i_cur)) begin
                o_next    = 4'(i);
                o_next_ok = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rt_block_writer.sv
// Stores the real-time write block and replays it onto the board-write bus.
// Define RT_SKIP_IDLE_CHAN_EN to skip channels with neither valid nor amp-enable set.
module rt_block_writer
    import rt_block_writer_pkg::*;
#(
    parameter int NUM_MOTORS   = 4,
    parameter int START_CYCLES = 4,
    parameter int GAP_CYCLES   = 3,
    parameter int CTRL_BITS    = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rt_write_en,
    input  logic [3:0]  rt_write_addr,
    input  logic [31:0] rt_write_data,
    output logic        bw_write_en,
    output logic        bw_reg_wen,
    output logic        bw_block_wen,
    output logic        bw_block_wstart,
    output logic [7:0]  bw_reg_waddr,
    output logic [31:0] bw_reg_wdata,
    output logic        dac_update,
    output logic        busy,
    output logic [7:0]  overrun_cnt
);

    localparam int CNT_MAX = (START_CYCLES > GAP_CYCLES) ? START_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t                r_state, w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [3:0]            r_chan, w_chan_next;
    logic [31:0]           r_dac [NUM_MOTORS];
    logic [CTRL_BITS-1:0]  r_ctrl;
    logic                  r_dac_update;
    logic [7:0]            r_overrun;

    logic [NUM_MOTORS-1:0] w_valid, w_amp;
    logic                  w_any_valid, w_any_active, w_first_ok, w_next_ok;
    logic [3:0]            w_first, w_next_chan;
    logic [31:0]           w_cur_data;
    logic                  w_busy, w_trigger;

    always_comb begin
        w_valid    = '0;
        w_amp      = '0;
        w_cur_data = '0;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            w_valid[i] = r_dac[i][RT_DAC_VALID_BIT];
            w_amp[i]   = r_dac[i][RT_AMP_EN_BIT];
            if (r_chan == 4'(i)) w_cur_data = r_dac[i];
        end
    end

    rt_chan_select #(.NUM_MOTORS(NUM_MOTORS)) u_sel (
        .i_valid      (w_valid),
        .i_amp_en     (w_amp),
        .i_cur        (r_chan),
        .o_any_valid  (w_any_valid),
        .o_any_active (w_any_active),
        .o_first      (w_first),
        .o_first_ok   (w_first_ok),
        .o_next       (w_next_chan),
        .o_next_ok    (w_next_ok)
    );

    assign w_busy    = (r_state != S_IDLE);
    assign w_trigger = (r_state == S_IDLE) && rt_write_en && (rt_write_addr == 4'(NUM_MOTORS));

    always_comb begin
        w_next      = r_state;
        w_chan_next = r_chan;
        case (r_state)
            S_IDLE:
                if (w_trigger) w_next = w_any_active ? S_WSTART : S_WQUAD;
            S_WSTART:
                if (r_cnt == CNT_W'(START_CYCLES - 1)) begin
                    w_next      = w_first_ok ? S_WRITE : S_BLK_WEN;
                    w_chan_next = w_first;
                end
            S_WRITE:
                w_next = S_WRITE_GAP;
            S_WRITE_GAP:
                if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    w_next      = w_next_ok ? S_WRITE : S_BLK_WEN;
                    w_chan_next = w_next_ok ? w_next_chan : r_chan;
                end
            S_BLK_WEN:
                if (r_cnt == CNT_W'(GAP_CYCLES)) w_next = (r_ctrl != '0) ? S_WQUAD_GAP : S_IDLE;
            S_WQUAD_GAP:
                if (r_cnt == CNT_W'(GAP_CYCLES - 1)) w_next = S_WQUAD;
            S_WQUAD:
                w_next = S_IDLE;
            default:
                w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy            = w_busy;
        bw_write_en     = w_busy;
        bw_block_wstart = (r_state == S_WSTART);
        bw_reg_wen      = (r_state == S_WRITE) || (r_state == S_WQUAD);
        bw_block_wen    = ((r_state == S_BLK_WEN) && (r_cnt == CNT_W'(GAP_CYCLES)))
                          || (r_state == S_WQUAD);
        bw_reg_waddr    = '0;
        bw_reg_wdata    = '0;
        if (r_state == S_WRITE) begin
            bw_reg_waddr = {r_chan + 4'd1, OFF_DAC_CTRL};
            bw_reg_wdata = w_cur_data;
        end else if (r_state == S_WQUAD) begin
            bw_reg_wdata = 32'(r_ctrl);
        end
        dac_update  = r_dac_update;
        overrun_cnt = r_overrun;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_chan       <= '0;
            r_ctrl       <= '0;
            r_dac_update <= 1'b0;
            r_overrun    <= '0;
            for (int i = 0; i < NUM_MOTORS; i++) r_dac[i] <= '0;
        end else begin
            r_state <= w_next;
            r_chan  <= w_chan_next;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);

            if ((r_state == S_IDLE) && rt_write_en) begin
                for (int i = 0; i < NUM_MOTORS; i++)
                    if (rt_write_addr == 4'(i)) r_dac[i] <= rt_write_data;
                if (w_trigger) r_ctrl <= rt_write_data[CTRL_BITS-1:0];
            end

            if (w_busy && rt_write_en && (r_overrun != 8'hFF)) r_overrun <= r_overrun + 8'd1;

            // Flags of the channel just written drop as it enters its gap.
            if (r_state == S_WRITE) begin
                for (int i = 0; i < NUM_MOTORS; i++) begin
                    if (r_chan == 4'(i)) begin
                        r_dac[i][RT_DAC_VALID_BIT] <= 1'b0;
                        r_dac[i][RT_AMP_EN_BIT]    <= 1'b0;
                    end
                end
            end

            if (r_state == S_WQUAD) r_ctrl <= '0;

            if ((r_state == S_IDLE) && (w_next == S_WSTART)) r_dac_update <= w_any_valid;
            else if (w_next == S_IDLE)                      r_dac_update <= 1'b0;
        end
    end

endmodule
